// File: rtl/phase_pkg.sv
// Shared types and constants for phase_select: FSM states, phase indices, the four legal
// quadrature patterns and the rotation helper used by the sequence checker.
package phase_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam logic [1:0] PH_0   = 2'd0;
  localparam logic [1:0] PH_90  = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

  // Bit order is {270,180,90,0}; the generator walks A -> B -> C -> D -> A.
  localparam logic [3:0] PAT_A = 4'b1001;
  localparam logic [3:0] PAT_B = 4'b0011;
  localparam logic [3:0] PAT_C = 4'b0110;
  localparam logic [3:0] PAT_D = 4'b1100;

  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic is_valid_pat(input logic [3:0] v);
    return (v == PAT_A) || (v == PAT_B) || (v == PAT_C) || (v == PAT_D);
  endfunction

endpackage

// File: rtl/phase_seq_check.sv
// Sticky checker for the quadrature phase rotation; only compiled when PHASE_CHECK_EN is
// defined, since phase_select instantiates it under that macro alone.
`ifdef PHASE_CHECK_EN
module phase_seq_check
  import phase_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ph_q,
  output logic       phase_err
);

  logic [3:0] prev_q;
  logic       err_q;
  logic       bad;

  // All-zero samples mean the generator is idle or in reset, so they are never judged.
  always_comb begin
    bad = 1'b0;
    if ((ph_q != 4'b0000) && (prev_q != 4'b0000)) begin
      bad = !is_valid_pat(ph_q) || (ph_q != rotl4(prev_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 4'b0000;
      err_q  <= 1'b0;
    end else begin
      prev_q <= ph_q;
      err_q  <= err_q | bad;
    end
  end

  assign phase_err = err_q;

endmodule
`endif

// File: rtl/phase_select.sv
// Glitch-free run-time selector of one of four quadrature phases sampled on clk.
// Defining PHASE_CHECK_EN adds the rotation checker; otherwise phase_err is tied low.
module phase_select
  import phase_pkg::*;
#(
  parameter int unsigned RESET_SEL = 0,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_0,
  input  logic       clk_90,
  input  logic       clk_180,
  input  logic       clk_270,
  input  logic [1:0] sel_in,
  input  logic       sel_valid,
  output logic       sel_ready,
  output logic       sel_done,
  output logic       sel_tmo,
  output logic [1:0] cur_sel,
  output logic       phase_out,
  output logic       phase_err
);

  localparam logic [1:0] ResetIdx = 2'(RESET_SEL);
  localparam logic [3:0] TmoLimit = 4'(TIMEOUT);

  logic [3:0] ph_q;
  state_e     state_q, state_d;
  logic [1:0] cur_q, cur_d;
  logic [1:0] nxt_q, nxt_d;
  logic [3:0] tmr_q, tmr_d;
  logic [3:0] tmr_inc;
  logic       expired;
  logic       out_q, out_d;
  logic       done_q, done_d;
  logic       tmo_q, tmo_d;

  assign tmr_inc   = tmr_q + 4'd1;
  assign expired   = (tmr_inc >= TmoLimit);
  assign sel_ready = (state_q == StRun) && !rst;

  // A switch first waits for the old phase to go low (DRAIN), then holds the output low
  // until the new phase is also low (HOLD), so neither edge of phase_out can be a runt.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    tmr_d   = tmr_q;
    out_d   = ph_q[cur_q];
    done_d  = 1'b0;
    tmo_d   = 1'b0;

    unique case (state_q)
      StRun: begin
        if (sel_valid && sel_ready) begin
          if (sel_in == cur_q) begin
            done_d = 1'b1;
          end else begin
            nxt_d   = sel_in;
            tmr_d   = 4'd0;
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        tmr_d = tmr_inc;
        if (expired) begin
          cur_d   = nxt_q;
          out_d   = 1'b0;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = StRun;
        end else if (!ph_q[cur_q]) begin
          state_d = StHold;
        end
      end

      StHold: begin
        out_d = 1'b0;
        if (!ph_q[nxt_q]) begin
          cur_d   = nxt_q;
          done_d  = 1'b1;
          state_d = StRun;
        end else begin
          tmr_d = tmr_inc;
          if (expired) begin
            cur_d   = nxt_q;
            done_d  = 1'b1;
            tmo_d   = 1'b1;
            state_d = StRun;
          end
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q    <= 4'b0000;
      state_q <= StRun;
      cur_q   <= ResetIdx;
      nxt_q   <= ResetIdx;
      tmr_q   <= 4'd0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      ph_q    <= {clk_270, clk_180, clk_90, clk_0};
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      tmr_q   <= tmr_d;
      out_q   <= out_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign cur_sel   = cur_q;
  assign phase_out = out_q;
  assign sel_done  = done_q;
  assign sel_tmo   = tmo_q;

`ifdef PHASE_CHECK_EN
  phase_seq_check u_seq_check (
    .clk       (clk),
    .rst       (rst),
    .ph_q      (ph_q),
    .phase_err (phase_err)
  );
`else
  assign phase_err = 1'b0;
`endif

endmodule

// File: tb/tb_phase_select.sv
// Randomized scoreboard bench for phase_select: a per-cycle output queue and a completion
// queue are filled by the stimulus side from a transaction-level model and drained by a monitor.
module tb_phase_select;

  localparam int unsigned RS   = 0;
  localparam int unsigned TO   = 15;
  localparam int          MAXE = 4096;
`ifdef PHASE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       c0, c90, c180, c270;
  logic [1:0] sel_in;
  logic       sel_valid;
  logic       sel_ready, sel_done, sel_tmo, phase_out, phase_err;
  logic [1:0] cur_sel;

  phase_select #(
    .RESET_SEL (RS),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_0     (c0),
    .clk_90    (c90),
    .clk_180   (c180),
    .clk_270   (c270),
    .sel_in    (sel_in),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .sel_done  (sel_done),
    .sel_tmo   (sel_tmo),
    .cur_sel   (cur_sel),
    .phase_out (phase_out),
    .phase_err (phase_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       po;
    logic [1:0] cur;
    logic       err;
  } cyc_t;

  typedef struct {
    int         edge_n;
    logic [1:0] cur;
    logic       tmo;
  } done_t;

  cyc_t  cq[$];
  done_t dq[$];
  int    checks = 0;
  int    errors = 0;

  logic [3:0] eff [0:MAXE-1];   // phase vector seen by the DUT at each edge (0 under reset)
  int         ne = 0;
  bit         ones_mode = 1'b0;
  bit         ovr_en = 1'b0;
  logic [3:0] ovr = 4'b0000;

  // Reference model state: current phase plus one pending switch described by its edges.
  logic [1:0] cur_m;
  bit         pend;
  int         ph, pm, pd;
  logic [1:0] pold, pnew;
  logic       ptmo;
  logic       err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] gen(input int n);
    if (ones_mode) return 4'hF;
    case (n % 4)
      0:       return 4'b1001;
      1:       return 4'b0011;
      2:       return 4'b0110;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic logic [3:0] in_at(input int n, input int now);
    return (n <= now) ? eff[n] : gen(n);
  endfunction

  // Walk the future phase sequence: wait for the old phase low, then the new phase low,
  // giving up after TO cycles in total.
  function automatic void plan(input int h, input logic [1:0] s);
    int   m = -1;
    int   d = -1;
    logic t = 1'b0;
    for (int k = 1; k <= int'(TO); k++) begin
      int         n;
      logic [3:0] v;
      n = h + k;
      v = in_at(n - 1, h);
      if (m < 0) begin
        if (k == int'(TO)) begin d = n; t = 1'b1; break; end
        if (!v[cur_m]) m = n;
      end else begin
        if (!v[s]) begin d = n; break; end
        if (k == int'(TO)) begin d = n; t = 1'b1; break; end
      end
    end
    pend = 1'b1; ph = h; pm = m; pd = d; pold = cur_m; pnew = s; ptmo = t;
    dq.push_back('{d, s, t});
  endfunction

  // vmode: 0 idle, 1 request, 2 keep poking sel_valid only while a switch is pending.
  task automatic step(input int vmode, input logic [1:0] s, input bit r);
    int         e;
    logic [3:0] in_v;
    bit         v, rdy;
    cyc_t       x;
    e = ne + 1;
    if (e >= MAXE) begin
      $display("FAIL edge_budget: got %0d want below %0d", e, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    #1;
    if (pend && e > pd) begin pend = 1'b0; cur_m = pnew; end
    if (r) begin
      pend  = 1'b0;
      cur_m = 2'(RS);
      for (int i = dq.size() - 1; i >= 0; i--) if (dq[i].edge_n >= e) dq.delete(i);
    end
    in_v   = ovr_en ? ovr : gen(e);
    eff[e] = r ? 4'h0 : in_v;
    v      = (vmode == 1) || (vmode == 2 && pend);
    rst = r;
    {c270, c180, c90, c0} = in_v;
    sel_valid = v;
    sel_in    = s;
    rdy = !r && !pend;
    #1;
    chk("sel_ready", 32'(sel_ready), 32'(rdy));
    if (v && rdy) begin
      if (s == cur_m) dq.push_back('{e, s, 1'b0});
      else plan(e, s);
    end
    if (r) begin
      x.po = 1'b0; x.cur = 2'(RS); x.err = 1'b0; err_m = 1'b0;
    end else begin
      if (pend && e > ph) begin
        x.po  = ((pm > 0 && e > pm) || (ptmo && e == pd)) ? 1'b0 : eff[e-1][pold];
        x.cur = (e < pd) ? pold : pnew;
      end else begin
        x.po  = eff[e-1][cur_m];
        x.cur = cur_m;
      end
      if (CHK && e >= 2 && eff[e-1] != 4'h0 && eff[e-2] != 4'h0 &&
          (!(eff[e-1] inside {4'b1001, 4'b0011, 4'b0110, 4'b1100}) ||
           eff[e-1] != {eff[e-2][2:0], eff[e-2][3]})) err_m = 1'b1;
      x.err = err_m;
    end
    cq.push_back(x);
    @(posedge clk);
    ne = e;
  endtask

  task automatic req(input logic [1:0] s, input bit poke);
    int guard = 0;
    step(1, s, 1'b0);
    while (pend && guard < 40) begin
      step(poke ? 2 : 0, 2'($urandom_range(0, 3)), 1'b0);
      guard++;
    end
  endtask

  // Monitor: compares every cycle's registered outputs and each sel_done pulse.
  int mon_e = 0;
  initial begin
    cyc_t  x;
    done_t y;
    forever begin
      @(posedge clk);
      #3;
      mon_e++;
      if (cq.size() > 0) begin
        x = cq.pop_front();
        chk("phase_out", 32'(phase_out), 32'(x.po));
        chk("cur_sel", 32'(cur_sel), 32'(x.cur));
        chk("phase_err", 32'(phase_err), 32'(x.err));
      end
      if (sel_done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sel_done: got pulse at edge %0d want none", mon_e);
        end else begin
          y = dq.pop_front();
          chk("done_edge", 32'(mon_e), 32'(y.edge_n));
          chk("done_cur", 32'(cur_sel), 32'(y.cur));
          chk("sel_tmo", 32'(sel_tmo), 32'(y.tmo));
        end
      end else if (sel_tmo) begin
        checks++; errors++;
        $display("FAIL sel_tmo: got 1 without sel_done at edge %0d want 0", mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; c0 = 1'b0; c90 = 1'b0; c180 = 1'b0; c270 = 1'b0;
    sel_valid = 1'b0; sel_in = 2'd0;
    for (int i = 0; i < MAXE; i++) eff[i] = 4'h0;
    cur_m = 2'(RS); pend = 1'b0; err_m = 1'b0;
    ph = 0; pm = -1; pd = 0; pold = 2'd0; pnew = 2'd0; ptmo = 1'b0;

    repeat (3) step(0, 2'd0, 1'b1);
    repeat (8) step(0, 2'd0, 1'b0);

    // Directed: adjacent, same-phase, opposite with busy pokes, back to 0.
    req(2'd1, 1'b0);
    req(2'd1, 1'b0);
    req(2'd3, 1'b1);
    req(2'd0, 1'b1);
    req(2'd2, 1'b0);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) step(0, 2'd0, 1'b0);
      req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Rotation break: 0101 straight after 0011.
    repeat (2) step(0, 2'd0, 1'b0);
    ovr_en = 1'b1;
    ovr = 4'b0011; step(0, 2'd0, 1'b0);
    ovr = 4'b0101; step(0, 2'd0, 1'b0);
    ovr_en = 1'b0;
    repeat (6) step(0, 2'd0, 1'b0);

    // Reset while holding the output low: the pending switch must vanish silently.
    step(1, cur_m ^ 2'd2, 1'b0);
    if (pend && pm > 0 && pm + 1 < pd) begin
      while (ne + 1 < pm + 1) step(0, 2'd0, 1'b0);
    end
    step(0, 2'd0, 1'b1);
    repeat (6) step(0, 2'd0, 1'b0);

    // Timeout: all phases stuck high so neither the old nor new phase ever drains.
    ones_mode = 1'b1;
    repeat (3) step(0, 2'd0, 1'b0);
    req((cur_m == 2'd3) ? 2'd0 : 2'd3, 1'b1);
    repeat (3) step(0, 2'd0, 1'b0);
    ones_mode = 1'b0;
    repeat (8) step(0, 2'd0, 1'b0);

    #10;
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
